cvex_soc: RTL and testbench
===========================

Name: cvex_soc

Overview:
- Minimal RISC-V SoC top for iCE40.
- Wraps an externally supplied VexRiscv core (simple iBus/dBus), and adds:
  - instruction RAM and data RAM with per-byte write masks;
  - a memory-mapped 8N1 UART;
  - an internal debug memory-load port used to preload programs while the CPU is held in reset.
- This block is the bus fabric, the memories, the UART and the reset/debug muxing. The CPU core itself is not part of this block.

Parameters:
- F_CLK, 12000000, clock frequency in Hz.
- BAUD, 115200, UART bit rate; bit period = F_CLK/BAUD clocks, integer-truncated.
- IRAM_WORDS, 2048, instruction RAM depth in 32-bit words.
- DRAM_WORDS, 2048, data RAM depth in 32-bit words.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous active-low reset, synchronously deasserted internally.
- PICO_UART0_RX  in  1  UART receive line, idle high.
- PICO_UART0_TX  out  1  UART transmit line, idle high.

Internal nets with fixed names (bench drives them by hierarchical force):
- cpu_n_reset (1): CPU core reset = RESET AND cpu_n_reset. Default-driven 1.
- dbg_mem_op (1): debug port owns memory write path when 1. Default-driven 0.
- dbg_wren (4): byte write enables.
- dbg_adr (32): byte address.
- dbg_do (32): write data.

Behaviour:
- Memory map:
  - IRAM 0x20000 + 4*IRAM_WORDS; CPU reset vector 0x20000.
  - DRAM 0x00000 + 4*DRAM_WORDS.
  - UART base 0x40000.
  - Decode uses address bits [18:17]: 00 DRAM, 01 IRAM, 10 UART. Word index = adr[n:2].
  - Unmapped reads return 0; unmapped writes are ignored.
- iBus:
  - cmd_ready is always 1.
  - rsp_valid one cycle after an accepted cmd, carrying the IRAM word. Fetch from DRAM is also allowed.
- dBus:
  - cmd_ready is always 1.
  - Writes complete in the accept cycle and produce no rsp.
  - Reads return rsp_valid plus the full 32-bit word one cycle later. The CPU extracts bytes/halfwords.
- Write mask derived from size and adr[1:0]:
  - byte: 0001 << adr[1:0];
  - half: 0011 << {adr[1],0};
  - word: 1111.
  - Write data is replicated per lane (byte into all 4 lanes, half into both halves).
- Debug port (dbg_mem_op=1): every clock, writes dbg_do into the IRAM or DRAM word at dbg_adr, lanes gated by dbg_wren. It has priority over the dBus write.
- Reset values:
  - PICO_UART0_TX=1.
  - UART busy=0, rx_valid=0.
  - Bus rsp_valid=0.
  - RAM contents are not reset.
- UART registers:
  - +0x0 write: start TX of byte[7:0]; ignored while busy.
  - +0x0 read: RX byte; clears rx_valid.
  - +0x4 read: bit0 tx_busy, bit1 rx_valid.
- UART TX frame: start bit 0, 8 data bits LSB first, stop bit 1, each lasting one bit period. busy is cleared at the end of the stop bit.
- UART RX:
  - 2-flop synchronizer.
  - Falling edge starts reception; samples are taken at mid-bit.
  - A stop bit of 0 discards the byte.
  - A new byte overwrites an unread one.
- Reset mid-operation:
  - Aborts any TX frame (line returns high immediately) and any RX in progress.
  - Drops pending rsp.

Optional Feature:
- CVEX_DBG_PORT_EN.
- Defined: debug nets exist and behave as above.
- Undefined:
  - dbg_mem_op, dbg_wren, dbg_adr and dbg_do are tied to 0, and cpu_n_reset is tied to 1.
  - Memories are loaded only via an init file (IRAM from "iram.hex" via $readmemh).

Test Plan:
- Byte access: hold cpu_n_reset=0 and dbg_mem_op=1 with dbg_wren=F, and load at 0x20000–0x2001C: 00000137, 03200793, 00f10623, 03100793, 00f106a3, 00d14503, 00c14503, 0000006f. Then release both.
  - Required: dBus write masks 0001 then 0010 at word 0x0C.
  - Required: x10 reads 0x31, then 0x32.
  - Required: DRAM word 3 = 0x00003132.
- Word/half store then lw: sw 0x12345678 then sh 0xABCD at +2 (mask 1100) -> lw returns 0xABCD5678.
- UART TX: program writes 0x55 to 0x40000 -> TX shows start bit, bits 1,0,1,0,1,0,1,0, stop bit, each F_CLK/BAUD clocks; status bit0 is 1 during the frame.
- UART RX: bench sends 0xA3 on PICO_UART0_RX -> status bit1 = 1; reading 0x40000 returns 0xA3 and clears bit1.
- Debug partial mask: dbg_wren=0100, dbg_do=0xFFFFFFFF to DRAM word 0 (previously 0) -> word reads 0x00FF0000.
- RESET asserted mid TX frame -> TX returns to 1 immediately, busy=0; after release, CPU refetches from 0x20000.

Source files
------------

// File: rtl/cvex_soc_if.sv
// CPU-side bus bundle for cvex_soc: VexRiscv simple iBus/dBus plus the gated
// CPU reset that the SoC hands back to the core.
interface cvex_soc_if;
   logic        ibus_cmd_valid;
   logic        ibus_cmd_ready;
   logic [31:0] ibus_cmd_pc;
   logic        ibus_rsp_valid;
   logic [31:0] ibus_rsp_inst;
   logic        dbus_cmd_valid;
   logic        dbus_cmd_ready;
   logic        dbus_cmd_wr;
   logic [1:0]  dbus_cmd_size;
   logic [31:0] dbus_cmd_adr;
   logic [31:0] dbus_cmd_data;
   logic        dbus_rsp_valid;
   logic [31:0] dbus_rsp_data;
   logic        cpu_rst_n;

   modport master (
      output ibus_cmd_valid, ibus_cmd_pc,
      output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_size, dbus_cmd_adr, dbus_cmd_data,
      input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_inst,
      input  dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data, cpu_rst_n
   );

   modport slave (
      input  ibus_cmd_valid, ibus_cmd_pc,
      input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_size, dbus_cmd_adr, dbus_cmd_data,
      output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_inst,
      output dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data, cpu_rst_n
   );
endinterface

// File: rtl/cvex_soc.sv
// cvex_soc: bus fabric, IRAM/DRAM, 8N1 UART and reset/debug muxing around an
// external VexRiscv core attached through cvex_soc_if.
// Map (adr[18:17]): 00 DRAM @0x00000, 01 IRAM @0x20000, 10 UART @0x40000.
// Optional macro CVEX_DBG_PORT_EN enables the internal debug memory-load nets.
// Without it the debug nets are tied off and IRAM content comes from iram.hex
// through the FPGA flow's memory-init step.
module cvex_soc #(
   parameter int unsigned F_CLK      = 12000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned IRAM_WORDS = 2048,
   parameter int unsigned DRAM_WORDS = 2048
) (
   input  logic      CLK,
   input  logic      RESET,
   input  logic      PICO_UART0_RX,
   output logic      PICO_UART0_TX,
   cvex_soc_if.slave bus
);
   localparam int unsigned DIV  = F_CLK / BAUD;
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV + 1);
   localparam int unsigned IAW  = $clog2(IRAM_WORDS);
   localparam int unsigned DAW  = $clog2(DRAM_WORDS);

   typedef enum logic [1:0] {SelNone, SelIram, SelDram, SelUart} sel_e;
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

   function automatic sel_e decode(input logic [31:0] a);
      if (a[18:17] == 2'b01 && 32'(a[16:2]) < IRAM_WORDS) return SelIram;
      if (a[18:17] == 2'b00 && 32'(a[16:2]) < DRAM_WORDS) return SelDram;
      if (a[18:17] == 2'b10 && a[16:3] == '0) return SelUart;
      return SelNone;
   endfunction

   // Reset: asserted asynchronously, released after two clean clock edges.
   logic [1:0] rst_sync;
   logic       rst_n;
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   logic        cpu_n_reset, dbg_mem_op;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_adr, dbg_do;
`ifdef CVEX_DBG_PORT_EN
   // Default drivers; the loader overrides them while the CPU is held in reset.
   assign cpu_n_reset = 1'b1;
   assign dbg_mem_op  = 1'b0;
   assign dbg_wren    = 4'b0000;
   assign dbg_adr     = '0;
   assign dbg_do      = '0;
`else
   assign cpu_n_reset = 1'b1;
   assign dbg_mem_op  = 1'b0;
   assign dbg_wren    = 4'b0000;
   assign dbg_adr     = '0;
   assign dbg_do      = '0;
   logic unused_dbg;
   assign unused_dbg = ^{dbg_mem_op, dbg_wren, dbg_adr, dbg_do};
`endif

   assign bus.cpu_rst_n      = rst_n & cpu_n_reset;
   assign bus.ibus_cmd_ready = 1'b1;
   assign bus.dbus_cmd_ready = 1'b1;

   logic d_rd, d_wr;
   assign d_rd = bus.dbus_cmd_valid & ~bus.dbus_cmd_wr;
   assign d_wr = bus.dbus_cmd_valid & bus.dbus_cmd_wr;

   // RAM write port: lane mask and lane-replicated data; the debug loader wins.
   logic [31:0] wr_adr, wr_data;
   logic [3:0]  wr_mask;
   always_comb begin
      wr_adr  = bus.dbus_cmd_adr;
      wr_data = bus.dbus_cmd_data;
      case (bus.dbus_cmd_size)
         2'd0: begin
            wr_mask = 4'b0001 << bus.dbus_cmd_adr[1:0];
            wr_data = {4{bus.dbus_cmd_data[7:0]}};
         end
         2'd1: begin
            wr_mask = 4'b0011 << {bus.dbus_cmd_adr[1], 1'b0};
            wr_data = {2{bus.dbus_cmd_data[15:0]}};
         end
         default: wr_mask = 4'b1111;
      endcase
      if (!d_wr) wr_mask = 4'b0000;
`ifdef CVEX_DBG_PORT_EN
      if (dbg_mem_op) begin
         wr_adr  = dbg_adr;
         wr_data = dbg_do;
         wr_mask = dbg_wren;
      end
`endif
   end

   logic [31:0] iram [IRAM_WORDS];
   logic [31:0] dram [DRAM_WORDS];
   logic [31:0] iram_i_q, dram_i_q, iram_d_q, dram_d_q;
   // Byte-lane writes and registered reads for both buses; contents never reset.
   always_ff @(posedge CLK) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_mask[b] && decode(wr_adr) == SelIram)
            iram[wr_adr[IAW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
         if (wr_mask[b] && decode(wr_adr) == SelDram)
            dram[wr_adr[DAW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
      iram_i_q <= iram[bus.ibus_cmd_pc[IAW+1:2]];
      dram_i_q <= dram[bus.ibus_cmd_pc[DAW+1:2]];
      iram_d_q <= iram[bus.dbus_cmd_adr[IAW+1:2]];
      dram_d_q <= dram[bus.dbus_cmd_adr[DAW+1:2]];
   end

   // UART register strobes (data register at +0x0 only).
   logic uart_rd, tx_start;
   logic tx_busy_q, rx_valid_q;
   logic [7:0] rx_data_q;
   assign uart_rd  = d_rd & (decode(bus.dbus_cmd_adr) == SelUart) & ~bus.dbus_cmd_adr[2];
   assign tx_start = d_wr & (decode(bus.dbus_cmd_adr) == SelUart) & ~bus.dbus_cmd_adr[2]
                     & ~tx_busy_q;

   sel_e        isel_q, dsel_q;
   logic        irsp_q, drsp_q;
   logic [31:0] uart_rd_q;
   // Response tracking: one-cycle latency, source captured at accept.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         irsp_q    <= 1'b0;
         drsp_q    <= 1'b0;
         isel_q    <= SelNone;
         dsel_q    <= SelNone;
         uart_rd_q <= '0;
      end else begin
         irsp_q    <= bus.ibus_cmd_valid;
         drsp_q    <= d_rd;
         isel_q    <= (decode(bus.ibus_cmd_pc) == SelUart) ? SelNone : decode(bus.ibus_cmd_pc);
         dsel_q    <= d_rd ? decode(bus.dbus_cmd_adr) : SelNone;
         uart_rd_q <= bus.dbus_cmd_adr[2] ? {30'b0, rx_valid_q, tx_busy_q} : {24'b0, rx_data_q};
      end
   end

   // Steer registered read data to each bus; unmapped reads return zero.
   always_comb begin
      bus.ibus_rsp_valid = irsp_q;
      bus.dbus_rsp_valid = drsp_q;
      bus.ibus_rsp_inst  = '0;
      bus.dbus_rsp_data  = '0;
      case (isel_q)
         SelIram: bus.ibus_rsp_inst = iram_i_q;
         SelDram: bus.ibus_rsp_inst = dram_i_q;
         default: ;
      endcase
      case (dsel_q)
         SelIram: bus.dbus_rsp_data = iram_d_q;
         SelDram: bus.dbus_rsp_data = dram_d_q;
         SelUart: bus.dbus_rsp_data = uart_rd_q;
         default: ;
      endcase
   end

   logic [9:0]    tx_shift_q;
   logic [3:0]    tx_bits_q;
   logic [CW-1:0] tx_cnt_q;
   // TX shifter: frame {stop, data, start} shifted out LSB first.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_bits_q  <= '0;
         tx_cnt_q   <= '0;
      end else if (tx_start) begin
         tx_busy_q  <= 1'b1;
         tx_shift_q <= {1'b1, bus.dbus_cmd_data[7:0], 1'b0};
         tx_bits_q  <= 4'd10;
         tx_cnt_q   <= CW'(DIV - 1);
      end else if (tx_busy_q) begin
         if (tx_cnt_q == '0) begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_bits_q  <= tx_bits_q - 4'd1;
            tx_cnt_q   <= CW'(DIV - 1);
            if (tx_bits_q == 4'd1) tx_busy_q <= 1'b0;
         end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
         end
      end
   end
   assign PICO_UART0_TX = tx_busy_q ? tx_shift_q[0] : 1'b1;

   rx_state_e     rx_state_q, rx_state_d;
   logic [2:0]    rx_sync_q;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bits_q, rx_bits_d;
   logic [7:0]    rx_shift_q, rx_shift_d, rx_data_d;
   logic          rx_valid_d, rx_in;
   assign rx_in = rx_sync_q[1];

   // RX state register plus synchronizer ([2] is the previous sample for edge detect).
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= StIdle;
         rx_sync_q  <= 3'b111;
         rx_cnt_q   <= '0;
         rx_bits_q  <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_sync_q  <= {rx_sync_q[1:0], PICO_UART0_RX};
         rx_cnt_q   <= rx_cnt_d;
         rx_bits_q  <= rx_bits_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // RX next state: sample mid-bit; a new byte wins over a same-cycle read clear.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bits_d  = rx_bits_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q & ~uart_rd;
      case (rx_state_q)
         StIdle: begin
            if (rx_sync_q[2] && !rx_in) begin
               rx_state_d = StStart;
               rx_cnt_d   = CW'(HALF - 1);
            end
         end
         StStart: begin
            if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CW'(1);
            else if (!rx_in) begin
               rx_state_d = StData;
               rx_cnt_d   = CW'(DIV - 1);
               rx_bits_d  = '0;
            end else rx_state_d = StIdle;
         end
         StData: begin
            if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CW'(1);
            else begin
               rx_shift_d = {rx_in, rx_shift_q[7:1]};
               rx_bits_d  = rx_bits_q + 3'd1;
               rx_cnt_d   = CW'(DIV - 1);
               if (rx_bits_q == 3'd7) rx_state_d = StStop;
            end
         end
         StStop: begin
            if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CW'(1);
            else begin
               if (rx_in) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end
               rx_state_d = StIdle;
            end
         end
         default: rx_state_d = StIdle;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{bus.ibus_cmd_pc[31:19], bus.ibus_cmd_pc[1:0],
                          bus.dbus_cmd_adr[31:19], wr_adr[31:19], wr_adr[1:0]};
endmodule

// File: tb/tb_cvex_soc.sv
// Bench for cvex_soc: acts as the CPU on the bus interface, keeps a word-level
// memory model and checks UART frames bit by bit.
module tb_cvex_soc;
   localparam int unsigned DIV = 12000000 / 115200;

   logic clk = 1'b0;
   logic rst_in, rx;
   logic tx;
   always #5 clk = ~clk;

   cvex_soc_if bus ();
   cvex_soc dut (
      .CLK          (clk),
      .RESET        (rst_in),
      .PICO_UART0_RX(rx),
      .PICO_UART0_TX(tx),
      .bus          (bus.slave)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] m_iram [16];
   logic [31:0] m_dram [16];
   logic [31:0] prog [8] = '{32'h00000137, 32'h03200793, 32'h00f10623, 32'h03100793,
                             32'h00f106a3, 32'h00d14503, 32'h00c14503, 32'h0000006f};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Model of a masked store: replace the addressed byte/half/word of the old word.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] adr,
                                         input logic [31:0] d, input logic [1:0] size);
      int unsigned sh;
      logic [31:0] m;
      if (size == 2'd0) begin
         sh = 8 * (adr % 4);
         m  = 32'hFF << sh;
      end else if (size == 2'd1) begin
         sh = 16 * ((adr / 2) % 2);
         m  = 32'hFFFF << sh;
      end else begin
         sh = 0;
         m  = 32'hFFFF_FFFF;
      end
      return (old & ~m) | ((d << sh) & m);
   endfunction

   task automatic dbus_write(input logic [31:0] adr, input logic [31:0] data,
                             input logic [1:0] size);
      @(negedge clk);
      bus.dbus_cmd_valid = 1'b1;
      bus.dbus_cmd_wr    = 1'b1;
      bus.dbus_cmd_adr   = adr;
      bus.dbus_cmd_data  = data;
      bus.dbus_cmd_size  = size;
      @(negedge clk);
      bus.dbus_cmd_valid = 1'b0;
      bus.dbus_cmd_wr    = 1'b0;
      check("wr_no_rsp", bus.dbus_rsp_valid, 0);
   endtask

   task automatic dbus_read(input logic [31:0] adr, output logic [31:0] data);
      @(negedge clk);
      bus.dbus_cmd_valid = 1'b1;
      bus.dbus_cmd_wr    = 1'b0;
      bus.dbus_cmd_adr   = adr;
      bus.dbus_cmd_size  = 2'd2;
      @(negedge clk);
      bus.dbus_cmd_valid = 1'b0;
      check("rd_rsp_valid", bus.dbus_rsp_valid, 1);
      data = bus.dbus_rsp_data;
   endtask

   task automatic ibus_fetch(input logic [31:0] pc, output logic [31:0] inst);
      @(negedge clk);
      bus.ibus_cmd_valid = 1'b1;
      bus.ibus_cmd_pc    = pc;
      @(negedge clk);
      bus.ibus_cmd_valid = 1'b0;
      check("if_rsp_valid", bus.ibus_rsp_valid, 1);
      inst = bus.ibus_rsp_inst;
   endtask

`ifdef CVEX_DBG_PORT_EN
   logic [31:0] f_adr, f_do;
   logic [3:0]  f_wren;
   task automatic dbg_write(input logic [31:0] adr, input logic [31:0] data,
                            input logic [3:0] wren);
      @(negedge clk);
      f_adr  = adr;
      f_do   = data;
      f_wren = wren;
      force dut.cpu_n_reset = 1'b0;
      force dut.dbg_mem_op  = 1'b1;
      force dut.dbg_wren    = f_wren;
      force dut.dbg_adr     = f_adr;
      force dut.dbg_do      = f_do;
      @(negedge clk);
      check("dbg_cpu_held", bus.cpu_rst_n, 0);
      release dut.cpu_n_reset;
      release dut.dbg_mem_op;
      release dut.dbg_wren;
      release dut.dbg_adr;
      release dut.dbg_do;
   endtask
`endif

   task automatic load_word(input logic [31:0] adr, input logic [31:0] data);
`ifdef CVEX_DBG_PORT_EN
      dbg_write(adr, data, 4'hF);
`else
      dbus_write(adr, data, 2'd2);
`endif
   endtask

   // Start a byte, then check every bit at its midpoint and busy around the frame.
   task automatic uart_tx_check(input logic [7:0] b);
      logic [31:0] d;
      logic [9:0]  frame;
      int unsigned n, target;
      frame = {1'b1, b, 1'b0};
      dbus_write(32'h40000, {24'h0, b}, 2'd0);
      dbus_read(32'h40004, d);
      check("tx_busy_set", d & 32'h1, 1);
      dbus_write(32'h40000, {24'h0, ~b}, 2'd0);  // must be ignored while busy
      n = 4;
      for (int k = 0; k < 10; k++) begin
         target = k * DIV + DIV / 2;
         repeat (target - n) @(negedge clk);
         n = target;
         check($sformatf("tx_bit%0d", k), tx, frame[k]);
      end
      repeat (10 * DIV + 1 - n) @(negedge clk);
      dbus_read(32'h40004, d);
      check("tx_busy_clr", d & 32'h1, 0);
      check("tx_idle", tx, 1);
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx = f[k];
         repeat (DIV) @(negedge clk);
      end
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, adr, data;
      logic [7:0]  r1, r2;
      logic        sel;
      logic [1:0]  size;
      int unsigned w;

      bus.ibus_cmd_valid = 1'b0;
      bus.ibus_cmd_pc    = '0;
      bus.dbus_cmd_valid = 1'b0;
      bus.dbus_cmd_wr    = 1'b0;
      bus.dbus_cmd_adr   = '0;
      bus.dbus_cmd_data  = '0;
      bus.dbus_cmd_size  = '0;
      rx     = 1'b1;
      rst_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_irsp", bus.ibus_rsp_valid, 0);
      check("rst_drsp", bus.dbus_rsp_valid, 0);
      check("rst_cpu", bus.cpu_rst_n, 0);
      rst_in = 1'b1;
      repeat (4) @(negedge clk);
      check("cpu_released", bus.cpu_rst_n, 1);
      check("cmd_ready", {bus.ibus_cmd_ready, bus.dbus_cmd_ready}, 2'b11);
      dbus_read(32'h40004, got);
      check("rst_status", got, 0);

      for (int i = 0; i < 16; i++) begin
         m_dram[i] = $urandom;
         m_iram[i] = $urandom;
         dbus_write(32'(i * 4), m_dram[i], 2'd2);
         dbus_write(32'h20000 + 32'(i * 4), m_iram[i], 2'd2);
      end

      for (int k = 0; k < 80; k++) begin
         sel  = 1'($urandom_range(0, 1));
         w    = $urandom_range(0, 15);
         size = 2'($urandom_range(0, 2));
         adr  = (sel ? 32'h20000 : 32'h0) + 32'(w * 4) + 32'($urandom_range(0, 3));
         data = $urandom;
         case ($urandom_range(0, 3))
            0: begin
               dbus_read(adr, got);
               check("rand_dbus_rd", got, sel ? m_iram[w] : m_dram[w]);
            end
            1: begin
               ibus_fetch(adr & ~32'h3, got);
               check("rand_fetch", got, sel ? m_iram[w] : m_dram[w]);
            end
            default: begin
               dbus_write(adr, data, size);
               if (sel) m_iram[w] = merge(m_iram[w], adr, data, size);
               else     m_dram[w] = merge(m_dram[w], adr, data, size);
            end
         endcase
      end

      // Unmapped space reads zero and writes outside a RAM do not alias into it.
      dbus_read(32'h60000, got);
      check("unmap_rd", got, 0);
      dbus_read(32'h02000, got);
      check("dram_oor_rd", got, 0);
      dbus_read(32'h40008, got);
      check("uart_oor_rd", got, 0);
      dbus_write(32'h02000, 32'hDEADBEEF, 2'd2);
      dbus_write(32'h60000, 32'hCAFEF00D, 2'd2);
      dbus_write(32'h22000, 32'h0BADF00D, 2'd2);
      dbus_read(32'h0, got);
      check("no_alias_dram", got, m_dram[0]);
      dbus_read(32'h20000, got);
      check("no_alias_iram", got, m_iram[0]);

      // Byte stores into word 3, as the sample program does.
      dbus_write(32'h0C, 32'h0, 2'd2);
      dbus_write(32'h0C, 32'h32, 2'd0);
      dbus_write(32'h0D, 32'h31, 2'd0);
      m_dram[3] = 32'h00003132;
      dbus_read(32'h0D, got);
      check("lbu_0d", (got >> 8) & 32'hFF, 32'h31);
      dbus_read(32'h0C, got);
      check("lbu_0c", got & 32'hFF, 32'h32);
      check("dram_w3", got, 32'h00003132);

      dbus_write(32'h10, 32'h12345678, 2'd2);
      dbus_write(32'h12, 32'h0000ABCD, 2'd1);
      m_dram[4] = 32'hABCD5678;
      dbus_read(32'h10, got);
      check("sw_sh_lw", got, 32'hABCD5678);

      for (int i = 0; i < 8; i++) begin
         load_word(32'h20000 + 32'(i * 4), prog[i]);
         m_iram[i] = prog[i];
      end
      for (int i = 0; i < 8; i++) begin
         ibus_fetch(32'h20000 + 32'(i * 4), got);
         check($sformatf("prog_fetch%0d", i), got, prog[i]);
      end

`ifdef CVEX_DBG_PORT_EN
      dbus_write(32'h0, 32'h0, 2'd2);
      dbg_write(32'h0, 32'hFFFFFFFF, 4'b0100);
      m_dram[0] = 32'h00FF0000;
      dbus_read(32'h0, got);
      check("dbg_lane_mask", got, 32'h00FF0000);
`endif

      uart_tx_check(8'h55);
      uart_tx_check(8'($urandom));

      uart_send(8'hA3, 1'b1);
      dbus_read(32'h40004, got);
      check("rx_valid_set", got, 32'h2);
      dbus_read(32'h40000, got);
      check("rx_data", got, 32'hA3);
      dbus_read(32'h40004, got);
      check("rx_valid_clr", got, 32'h0);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      uart_send(r1, 1'b1);
      uart_send(r2, 1'b1);
      dbus_read(32'h40000, got);
      check("rx_overwrite", got, {24'h0, r2});
      uart_send(8'h5A, 1'b0);
      dbus_read(32'h40004, got);
      check("rx_bad_stop", got, 32'h0);

      // Reset in the middle of a TX frame with a dBus response in flight.
      dbus_write(32'h40000, 32'h00, 2'd0);
      repeat (3 * DIV) @(negedge clk);
      check("tx_mid_frame", tx, 0);
      bus.dbus_cmd_valid = 1'b1;
      bus.dbus_cmd_wr    = 1'b0;
      bus.dbus_cmd_adr   = 32'h0;
      @(posedge clk);
      #2;
      check("rsp_pending", bus.dbus_rsp_valid, 1);
      rst_in = 1'b0;
      #1;
      check("rst_tx_high", tx, 1);
      check("rst_rsp_drop", bus.dbus_rsp_valid, 0);
      check("rst_cpu_mid", bus.cpu_rst_n, 0);
      bus.dbus_cmd_valid = 1'b0;
      @(negedge clk);
      rst_in = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_tx", tx, 1);
      dbus_read(32'h40004, got);
      check("post_rst_status", got, 0);
      ibus_fetch(32'h20000, got);
      check("refetch_vector", got, m_iram[0]);
      dbus_read(32'h10, got);
      check("ram_kept", got, m_dram[4]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
